// File: rtl/rbm_dma_load_engine.sv
// rtl/rbm_dma_load_engine.sv - DMA load engine unpacking multi-lane beats into the RBM data buffer
// Optional feature macro: RBM_BIAS_SENTINEL_EN (bias sentinel write after the data block)
module rbm_dma_load_engine #(
    parameter int ELEM_W    = 8,
    parameter int LANES     = 4,
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 9,
    parameter int FIRST_IDX = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic                      start,
    input  logic [31:0]               base_index,
    input  logic [15:0]               length,
    output logic                      rd_request,
    input  logic                      rd_grant,
    output logic [31:0]               rd_index,
    output logic [31:0]               rd_length,
    input  logic [ELEM_W*LANES-1:0]   data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic [ADDR_W-1:0]         buf_addr,
    output logic [ELEM_W-1:0]         buf_data,
    output logic                      buf_wen,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_complete,
    output logic                      err_len
);

    localparam int BEAT_W = ELEM_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef RBM_BIAS_SENTINEL_EN
    localparam int S_BIAS = 1;
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_BEAT, S_UNPACK, S_SENTINEL, S_DONE
    } state_t;
    localparam state_t S_AFTER_DATA = S_SENTINEL;
`else
    localparam int S_BIAS = 0;
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_BEAT, S_UNPACK, S_DONE
    } state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [31:0]         idx_q;
    logic [15:0]         len_q;
    logic [15:0]         cnt_q;
    logic [LANE_W-1:0]   lane_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                rd_complete_q;
    logic                err_len_q;

    logic                len_fits;
    logic                start_ok;
    logic                start_bad;
    logic                last_elem;
    logic                lane_last;

    // Length check covers data plus the optional bias entry so later address math cannot wrap
    assign len_fits  = (32'(FIRST_IDX) + 32'(length) + 32'(S_BIAS)) <= 32'(DEPTH);
    assign start_ok  = step && start && (state_q == S_IDLE) && len_fits;
    assign start_bad = step && start && (state_q == S_IDLE) && !len_fits;
    assign last_elem = (cnt_q == (len_q - 16'd1));
    assign lane_last = (lane_q == LANE_W'(LANES - 1));

    assign rd_index    = idx_q;
    assign rd_length   = {16'd0, len_q};
    assign rd_complete = rd_complete_q || (state_q == S_DONE);
    assign err_len     = err_len_q;

    // Next-state and combinational outputs; everything that acts is gated by step
    always_comb begin
        state_d    = state_q;
        rd_request = (state_q == S_REQ);
        data_ready = 1'b0;
        buf_wen    = 1'b0;
        buf_addr   = '0;
        buf_data   = '0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (length == 16'd0) ? S_AFTER_DATA : S_REQ;
                end
            end
            S_REQ: begin
                if (step && rd_grant) begin
                    state_d = S_WAIT_BEAT;
                end
            end
            S_WAIT_BEAT: begin
                data_ready = step;
                if (step && data_valid) begin
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                buf_wen  = step;
                buf_addr = ADDR_W'(FIRST_IDX) + cnt_q[ADDR_W-1:0];
                buf_data = beat_q[int'(lane_q)*ELEM_W +: ELEM_W];
                if (step) begin
                    if (last_elem) begin
                        state_d = S_AFTER_DATA;
                    end else if (lane_last) begin
                        state_d = S_WAIT_BEAT;
                    end
                end
            end
`ifdef RBM_BIAS_SENTINEL_EN
            S_SENTINEL: begin
                buf_wen  = step;
                buf_addr = ADDR_W'(FIRST_IDX) + len_q[ADDR_W-1:0];
                buf_data = ELEM_W'(1);
                if (step) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done = step;
                if (step) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request parameters, beat holding register and element counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            lane_q        <= '0;
            beat_q        <= '0;
            rd_complete_q <= 1'b0;
            err_len_q     <= 1'b0;
        end else if (step) begin
            state_q   <= state_d;
            err_len_q <= start_bad;
            if (start_ok) begin
                idx_q         <= base_index;
                len_q         <= length;
                cnt_q         <= '0;
                rd_complete_q <= 1'b0;
            end
            if (state_q == S_WAIT_BEAT && data_valid) begin
                beat_q <= data_in;
                lane_q <= '0;
            end
            if (state_q == S_UNPACK) begin
                cnt_q  <= cnt_q + 16'd1;
                lane_q <= lane_q + LANE_W'(1);
            end
            if (state_q == S_DONE) begin
                rd_complete_q <= 1'b1;
            end
        end else begin
            err_len_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rbm_dma_load_engine.sv
// tb/tb_rbm_dma_load_engine.sv - scoreboard bench for rbm_dma_load_engine
module tb_rbm_dma_load_engine;

    localparam int ELEM_W    = 8;
    localparam int LANES     = 4;
    localparam int DEPTH     = 512;
    localparam int ADDR_W    = 9;
    localparam int FIRST_IDX = 1;
    localparam int BEAT_W    = ELEM_W * LANES;
`ifdef RBM_BIAS_SENTINEL_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                step = 1'b0;
    logic                start = 1'b0;
    logic [31:0]         base_index = '0;
    logic [15:0]         length = '0;
    logic                rd_request;
    logic                rd_grant = 1'b0;
    logic [31:0]         rd_index;
    logic [31:0]         rd_length;
    logic [BEAT_W-1:0]   data_in = '0;
    logic                data_valid = 1'b0;
    logic                data_ready;
    logic [ADDR_W-1:0]   buf_addr;
    logic [ELEM_W-1:0]   buf_data;
    logic                buf_wen;
    logic                busy;
    logic                done;
    logic                rd_complete;
    logic                err_len;

    rbm_dma_load_engine #(
        .ELEM_W(ELEM_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIRST_IDX(FIRST_IDX)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .start(start),
        .base_index(base_index), .length(length),
        .rd_request(rd_request), .rd_grant(rd_grant),
        .rd_index(rd_index), .rd_length(rd_length),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_wen(buf_wen),
        .busy(busy), .done(done), .rd_complete(rd_complete), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [BEAT_W-1:0] beat_q[$];
    int exp_addr_q[$];
    int exp_data_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int wr_count = 0;
    bit req_seen = 0;
    logic [31:0] exp_idx = '0;
    logic [31:0] exp_len = '0;
    int step_mode = 0;
    int grant_pct = 100;
    int valid_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every buffer write against the scoreboard and tracks protocol events
    always @(negedge clk) begin
        if (!rst) begin
            if (buf_wen) begin
                wr_count++;
                check("wen_with_step", step, 1'b1);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    check("wr_addr", buf_addr, exp_addr_q.pop_front());
                    check("wr_data", buf_data, exp_data_q.pop_front());
                end
            end
            if (rd_request) begin
                req_seen = 1;
                check("rd_index", rd_index, exp_idx);
                check("rd_length", rd_length, exp_len);
            end
            if (busy) check("rd_complete_while_busy", rd_complete, 1'b0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_len) err_cnt++;
            if (data_valid && data_ready) void'(beat_q.pop_front());
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (step_mode)
            0: step = 1'b1;
            1: step = ~step;
            default: step = ($urandom_range(99) < 70);
        endcase
        rd_grant   = rd_request && ($urandom_range(99) < grant_pct);
        data_valid = (beat_q.size() > 0) && ($urandom_range(99) < valid_pct);
        data_in    = (beat_q.size() > 0) ? beat_q[0] : '0;
    endtask

    // Reference model: element i is lane (i mod LANES) of beat (i div LANES), at FIRST_IDX+i
    task automatic prep_load(input int n);
        logic [BEAT_W-1:0] b;
        int nb;
        nb = (n + LANES - 1) / LANES;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < LANES; k++) begin
                b[k*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
                if (j*LANES + k < n) begin
                    exp_addr_q.push_back(FIRST_IDX + j*LANES + k);
                    exp_data_q.push_back(int'(b[k*ELEM_W +: ELEM_W]));
                end
            end
            beat_q.push_back(b);
        end
        if (S == 1) begin
            exp_addr_q.push_back(FIRST_IDX + n);
            exp_data_q.push_back(1);
        end
    endtask

    task automatic issue_start(input int n, input logic [31:0] base, output int st);
        exp_idx = base;
        exp_len = 32'(n);
        req_seen = 0;
        @(posedge clk);
        #1;
        step = 1'b1;
        start = 1'b1;
        length = 16'(n);
        base_index = base;
        rd_grant = 1'b0;
        data_valid = 1'b0;
        st = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input logic [31:0] base, input bit ok, output int lat);
        int d0, e0, st;
        d0 = done_cnt;
        e0 = err_cnt;
        lat = -1;
        if (ok) prep_load(n);
        issue_start(n, base, st);
        if (ok) begin
            for (int i = 0; i < 20000 && done_cnt == d0; i++) tick();
            check("done_seen", done_cnt - d0, 1);
            lat = done_cyc - st;
            check("busy_after_done", busy, 1'b0);
            check("rd_complete_after_done", rd_complete, 1'b1);
            tick();
            tick();
            check("done_single_pulse", done_cnt - d0, 1);
            check("writes_left", exp_addr_q.size(), 0);
            check("beats_left", beat_q.size(), 0);
            check("req_seen", req_seen, n > 0);
        end else begin
            repeat (4) tick();
            check("err_len_pulse", err_cnt - e0, 1);
            check("no_req_on_reject", req_seen, 1'b0);
            check("busy_on_reject", busy, 1'b0);
            check("no_done_on_reject", done_cnt - d0, 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_index"}, rd_index, 0);
        check({tag, "_rd_length"}, rd_length, 0);
        check({tag, "_ctl"}, {rd_request, data_ready, buf_addr, buf_data, buf_wen,
                              busy, done, rd_complete, err_len}, 0);
    endtask

    initial begin
        int lat, st, w0, nmax;
        bit hit;
        nmax = DEPTH - FIRST_IDX - S;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        step = 1'b1;

        // zero-wait load of 6 elements, latency from start to done pulse
        step_mode = 0; grant_pct = 100; valid_pct = 100;
        run_load(6, 32'h40, 1'b1, lat);
        check("latency_n6", lat, 1 + 2 + 6 + S + 1);

        // step toggling with sparse beats
        step_mode = 1; valid_pct = 30;
        run_load(4, $urandom, 1'b1, lat);

        // length boundary
        step_mode = 0; valid_pct = 100;
        run_load(nmax + 1, 32'h1000, 1'b0, lat);
        run_load(nmax, 32'h2000, 1'b1, lat);

        // empty load
        run_load(0, 32'h3000, 1'b1, lat);
        check("latency_n0", lat, 1 + S);

        // reset after two writes of an 8-element load
        w0 = wr_count;
        hit = 0;
        prep_load(8);
        issue_start(8, 32'h55, st);
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            @(negedge clk);
            #1;
            if (wr_count >= w0 + 2) hit = 1;
        end
        check("reached_two_writes", hit, 1'b1);
        rst = 1'b1;
        data_valid = 1'b0;
        rd_grant = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        beat_q.delete();
        @(posedge clk);
        #1;
        check_idle_outputs("midload_reset");
        rst = 1'b0;
        w0 = wr_count;
        repeat (5) tick();
        check("no_writes_after_reset", wr_count - w0, 0);
        run_load(3, 32'h77, 1'b1, lat);

        // randomized loads
        for (int r = 0; r < 6; r++) begin
            step_mode = 2;
            grant_pct = $urandom_range(100, 30);
            valid_pct = $urandom_range(100, 30);
            run_load($urandom_range(40, 0), $urandom, 1'b1, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
